// File: rtl/sal_rd_resp_merger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sal_rd_resp_merger: re-orders per-bank read beats onto one AXI R channel  |
// | by sequence number. Optional watchdog: define SAL_RD_RESP_TIMEOUT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sal_rd_resp_merger #(
  parameter int BK_CNT      = 4,
  parameter int DATA_W      = 128,
  parameter int ID_W        = 4,
  parameter int SEQ_W       = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BK_CNT-1:0]        bk_rvalid,
  output logic [BK_CNT-1:0]        bk_rready,
  input  logic [BK_CNT*ID_W-1:0]   bk_rid,
  input  logic [BK_CNT*DATA_W-1:0] bk_rdata,
  input  logic [BK_CNT-1:0]        bk_rlast,
  input  logic [BK_CNT*SEQ_W-1:0]  bk_seq_num,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [ID_W-1:0]          rid,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     err_timeout
);

  localparam int c_ENT_W = DATA_W + ID_W + 1;

  logic [SEQ_W-1:0]   exp_seq_q, exp_seq_d;
  logic [1:0]         fifo_cnt_q, fifo_cnt_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [c_ENT_W-1:0] mem_q [2];

  logic [BK_CNT-1:0]  sel;
  logic               found;
  logic [c_ENT_W-1:0] sel_entry;
  logic               can_push;
  logic               push;
  logic               pop;
  logic [c_ENT_W-1:0] head;

  // Lowest-index bank carrying the expected sequence number wins.
  always_comb begin
    sel       = '0;
    found     = 1'b0;
    sel_entry = '0;
    for (int i = 0; i < BK_CNT; i++) begin
      if (!found && bk_rvalid[i] &&
          (bk_seq_num[i*SEQ_W +: SEQ_W] == exp_seq_q)) begin
        found     = 1'b1;
        sel[i]    = 1'b1;
        sel_entry = {bk_rlast[i], bk_rid[i*ID_W +: ID_W], bk_rdata[i*DATA_W +: DATA_W]};
      end
    end
  end

  // Ready is derived from FIFO occupancy only, never from rready.
  assign can_push  = (fifo_cnt_q < 2'd2) && !rst;
  assign bk_rready = sel & {BK_CNT{can_push}};
  assign push      = found && can_push;
  assign pop       = (fifo_cnt_q != 2'd0) && rready;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    exp_seq_d = exp_seq_q;
    if (push && sel_entry[c_ENT_W-1]) begin
      exp_seq_d = exp_seq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_seq_q  <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      exp_seq_q  <= exp_seq_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sel_entry;
    end
  end

  assign head   = mem_q[rd_ptr_q];
  assign rvalid = (fifo_cnt_q != 2'd0);
  assign rlast  = head[c_ENT_W-1];
  assign rid    = head[DATA_W +: ID_W];
  assign rdata  = head[DATA_W-1:0];
  assign rresp  = 2'b00;

`ifdef SAL_RD_RESP_TIMEOUT_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [c_WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;

  // Counts cycles where some bank waits but none holds the expected burst.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (push || (bk_rvalid == '0)) begin
      wd_cnt_d = '0;
    end else if (!found && (wd_cnt_q != c_WD_W'(TIMEOUT_CYC))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    err_d = err_q | (wd_cnt_d == c_WD_W'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign err_timeout        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sal_rd_resp_merger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sal_rd_resp_merger: directed self-checking bench for the R merger.     |
// | Revision: 1.1                                                            |
// +--------------------------------------------------------------------------+
module tb_sal_rd_resp_merger;

    localparam int BK = 4;
    localparam int DW = 128;
    localparam int IW = 4;
    localparam int SW = 8;

    typedef struct packed {
        logic [SW-1:0] seq;
        logic          last;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } bbeat_t;

    typedef logic [DW+IW:0] rbeat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [BK-1:0]    bk_rvalid;
    logic [BK-1:0]    bk_rready;
    logic [BK*IW-1:0] bk_rid;
    logic [BK*DW-1:0] bk_rdata;
    logic [BK-1:0]    bk_rlast;
    logic [BK*SW-1:0] bk_seq_num;
    logic             rvalid;
    logic             rready;
    logic [IW-1:0]    rid;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             err_timeout;

    int     checks = 0;
    int     errors = 0;
    bbeat_t bq [BK][$];
    rbeat_t rq [$];

    sal_rd_resp_merger #(
        .BK_CNT     (BK),
        .DATA_W     (DW),
        .ID_W       (IW),
        .SEQ_W      (SW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bk_rvalid  (bk_rvalid),
        .bk_rready  (bk_rready),
        .bk_rid     (bk_rid),
        .bk_rdata   (bk_rdata),
        .bk_rlast   (bk_rlast),
        .bk_seq_num (bk_seq_num),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(int b, int s, int k);
        return {96'hA5A5, 8'(b), 8'(s), 8'(k), 8'h5A};
    endfunction

    function automatic rbeat_t exp_r(int b, int s, int k, int n);
        return {(k == n - 1), IW'(b), mk_data(b, s, k)};
    endfunction

    function automatic rbeat_t rq_at(int k);
        if (k < rq.size()) return rq[k];
        return 'x;
    endfunction

    task automatic push_burst(int b, int s, int n);
        bbeat_t e;
        for (int k = 0; k < n; k++) begin
            e.seq  = SW'(s);
            e.last = (k == n - 1);
            e.id   = IW'(b);
            e.data = mk_data(b, s, k);
            bq[b].push_back(e);
        end
    endtask

    task automatic drive();
        bbeat_t e;
        for (int i = 0; i < BK; i++) begin
            if (bq[i].size() != 0) begin
                e = bq[i][0];
                bk_rvalid[i]           = 1'b1;
                bk_rlast[i]            = e.last;
                bk_rid[i*IW +: IW]     = e.id;
                bk_rdata[i*DW +: DW]   = e.data;
                bk_seq_num[i*SW +: SW] = e.seq;
            end else begin
                bk_rvalid[i]           = 1'b0;
                bk_rlast[i]            = 1'b0;
                bk_rid[i*IW +: IW]     = '0;
                bk_rdata[i*DW +: DW]   = '0;
                bk_seq_num[i*SW +: SW] = '0;
            end
        end
    endtask

    task automatic cyc();
        logic [BK-1:0] acc;
        #1;
        acc = bk_rvalid & bk_rready;
        if (rvalid && rready) rq.push_back({rlast, rid, rdata});
        @(negedge clk);
        for (int i = 0; i < BK; i++) begin
            if (acc[i]) void'(bq[i].pop_front());
        end
        drive();
    endtask

    task automatic idle(int budget);
        int n = 0;
        while (((bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size()) != 0 || rvalid)
               && n < budget) begin
            cyc();
            n++;
        end
        chk("idle_budget", n < budget);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < BK; i++) bq[i].delete();
        drive();
        cyc();
        rst = 1'b0;
        drive();
        rq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        rready     = 1'b1;
        bk_rvalid  = '0;
        bk_rlast   = '0;
        bk_rid     = '0;
        bk_rdata   = '0;
        bk_seq_num = '0;
        @(negedge clk);
        @(negedge clk);
        bk_rvalid[0] = 1'b1;
        #1;
        chk("rst_rvalid", rvalid === 1'b0);
        chk("rst_bk_rready", bk_rready === 4'b0000);
        chk("rst_exp_seq", dut.exp_seq_q === 8'd0);
        chk("rst_err", err_timeout === 1'b0);
        chk("rst_rresp", rresp === 2'b00);
        bk_rvalid[0] = 1'b0;
        do_reset();

        push_burst(2, 0, 4);
        drive();
        #1;
        chk("t1_bk_rready", bk_rready === 4'b0100);
        chk("t1_rvalid_pre", rvalid === 1'b0);
        cyc();
        #1;
        chk("t1_rvalid_next", rvalid === 1'b1);
        idle(50);
        chk("t1_count", rq.size() == 4);
        for (int k = 0; k < 4; k++) chk("t1_beat", rq_at(k) === exp_r(2, 0, k, 4));
        chk("t1_exp_seq", dut.exp_seq_q === 8'd1);

        do_reset();
        push_burst(1, 1, 2);
        drive();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t2_stall", bk_rready[1] === 1'b0);
            cyc();
        end
        push_burst(3, 0, 2);
        drive();
        idle(50);
        chk("t2_count", rq.size() == 4);
        chk("t2_b0", rq_at(0) === exp_r(3, 0, 0, 2));
        chk("t2_b1", rq_at(1) === exp_r(3, 0, 1, 2));
        chk("t2_b2", rq_at(2) === exp_r(1, 1, 0, 2));
        chk("t2_b3", rq_at(3) === exp_r(1, 1, 1, 2));

        do_reset();
        rready = 1'b0;
        push_burst(0, 0, 4);
        drive();
        cyc();
        cyc();
        #1;
        chk("t3_full_ready", bk_rready[0] === 1'b0);
        chk("t3_rvalid", rvalid === 1'b1);
        chk("t3_rdata", rdata === mk_data(0, 0, 0));
        chk("t3_left", bq[0].size() == 2);
        cyc();
        cyc();
        cyc();
        #1;
        chk("t3_rdata_hold", rdata === mk_data(0, 0, 0));
        chk("t3_rid_hold", rid === 4'd0);
        chk("t3_left_hold", bq[0].size() == 2);
        rready = 1'b1;
        idle(50);
        chk("t3_count", rq.size() == 4);
        for (int k = 0; k < 4; k++) chk("t3_beat", rq_at(k) === exp_r(0, 0, k, 4));

        do_reset();
        push_burst(0, 0, 4);
        drive();
        cyc();
        cyc();
        #1;
        chk("t5_pre_rvalid", rvalid === 1'b1);
        chk("t5_pre_exp", dut.exp_seq_q === 8'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_rvalid", rvalid === 1'b0);
        chk("t5_exp_seq", dut.exp_seq_q === 8'd0);
        bq[0].delete();
        rq.delete();
        push_burst(1, 0, 2);
        drive();
        idle(50);
        chk("t5_count", rq.size() == 2);
        chk("t5_b0", rq_at(0) === exp_r(1, 0, 0, 2));
        chk("t5_b1", rq_at(1) === exp_r(1, 0, 1, 2));
        chk("t5_exp_end", dut.exp_seq_q === 8'd1);

        do_reset();
        for (int s = 0; s < 255; s++) push_burst(s % 4, s, 1);
        drive();
        idle(2000);
        chk("t4_pre_count", rq.size() == 255);
        chk("t4_pre_exp", dut.exp_seq_q === 8'd255);
        rq.delete();
        push_burst(2, 0, 2);
        push_burst(1, 255, 2);
        drive();
        idle(50);
        chk("t4_count", rq.size() == 4);
        chk("t4_b0", rq_at(0) === exp_r(1, 255, 0, 2));
        chk("t4_b1", rq_at(1) === exp_r(1, 255, 1, 2));
        chk("t4_b2", rq_at(2) === exp_r(2, 0, 0, 2));
        chk("t4_b3", rq_at(3) === exp_r(2, 0, 1, 2));
        chk("t4_exp_end", dut.exp_seq_q === 8'd1);

        do_reset();
        push_burst(0, 5, 1);
        drive();
        repeat (15) cyc();
        #1;
        chk("t6_err_15", err_timeout === 1'b0);
        chk("t6_no_accept", bk_rready === 4'b0000);
        cyc();
        #1;
`ifdef SAL_RD_RESP_TIMEOUT_EN
        chk("t6_err_16", err_timeout === 1'b1);
        bq[0].delete();
        drive();
        repeat (5) cyc();
        #1;
        chk("t6_sticky", err_timeout === 1'b1);
`else
        chk("t6_err_off", err_timeout === 1'b0);
        repeat (10) cyc();
        #1;
        chk("t6_err_off_late", err_timeout === 1'b0);
`endif
        do_reset();
        #1;
        chk("t6_err_rst", err_timeout === 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
